// File: rtl/mem_responder.sv
// mem_responder: single-request memory responder. A request is latched when
// the block is idle, held for LATENCY cycles, then completed with a one-cycle
// done pulse. Reads register storage data onto data_out and writes commit to
// storage. Requests that arrive while busy are dropped.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,   // word-address bits, depth = 2**ADDR_WIDTH
  parameter int LATENCY    = 4    // accept-to-completion cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] data_out
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [15:0]           r_wdata;
  logic                  r_done;
  logic [15:0]           r_dout;
  logic [15:0]           r_mem [0:(1<<ADDR_WIDTH)-1];
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_unused_addr;

  // Byte bit and bits above the word index are deliberately dropped
  // (address space aliases); fold them here so they are consumed.
  assign w_unused_addr = ^addr;

  // State register; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus accept/complete strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: if (enable) begin
        w_accept    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: if (r_cnt == 4'd0) begin
        w_complete  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latency counter, done pulse and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 4'd0;
      r_done <= 1'b0;
      r_dout <= 16'h0000;
    end else begin
      r_done <= w_complete;
      if (w_accept)
        r_cnt <= 4'(LATENCY - 1);
      else if (r_state == WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_complete && !r_wr)
        r_dout <= r_mem[r_widx];
    end
  end

  // Request fields are captured only on accept; enable while busy is ignored.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_wr    <= wr;
      r_widx  <= addr[ADDR_WIDTH:1];
      r_wdata <= data_in;
    end
  end

  // Storage write port; reset never touches contents, and an abandoned
  // write never reaches here because reset blocks completion.
  always_ff @(posedge clk) begin
    if (!rst && w_complete && r_wr)
      r_mem[r_widx] <= r_wdata;
  end

  assign busy     = (r_state == WAIT);
  assign done     = r_done;
  assign data_out = r_dout;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=1 hand sequence, a table of directed
// per-cycle vectors, then randomized traffic against a transaction model.
module tb_mem_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst, enable, wr;
  logic [15:0] addr, data_in;
  logic        busy, done;
  logic [15:0] data_out;

  logic        rst1, en1, wr1;
  logic [15:0] addr1, din1;
  logic        busy1, done1;
  logic [15:0] dout1;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .busy(busy), .done(done), .data_out(data_out)
  );

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .wr(wr1), .addr(addr1),
    .data_in(din1), .busy(busy1), .done(done1), .data_out(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: a request accepted at edge n completes at edge n+LAT.
  int          edge_n = 0;
  bit          m_pending = 0;
  int          m_done_edge;
  bit          m_wr;
  int          m_widx;
  logic [15:0] m_wdata;
  bit          m_busy = 0, m_done = 0;
  logic [15:0] m_dout = 16'h0000;
  logic [15:0] m_mem [256];

  task automatic model_edge();
    edge_n++;
    m_done = 0;
    if (rst) begin
      m_pending = 0;
      m_dout    = 16'h0000;
    end else if (m_pending) begin
      if (edge_n == m_done_edge) begin
        m_pending = 0;
        m_done    = 1;
        if (m_wr) m_mem[m_widx] = m_wdata;
        else      m_dout = m_mem[m_widx];
      end
    end else if (enable) begin
      m_pending   = 1;
      m_done_edge = edge_n + LAT;
      m_wr        = wr;
      m_widx      = (int'(addr) / 2) % 256;
      m_wdata     = data_in;
    end
    m_busy = m_pending;
  endtask

  // Advance one edge and sample just after it; inputs stay stable across it.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, en, wr;
    logic [15:0] addr, din;
    logic        busy, done;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic e, logic w, logic [15:0] a, logic [15:0] d,
                              logic b, logic dn, logic [15:0] o);
    vec_t v;
    v.rst = r; v.en = e; v.wr = w; v.addr = a; v.din = d;
    v.busy = b; v.done = dn; v.dout = o;
    tbl.push_back(v);
  endfunction

  function automatic void addw(int n, logic b, logic [15:0] o);
    for (int i = 0; i < n; i++) add(0, 0, 0, 16'h0, 16'h0, b, 0, o);
  endfunction

  initial begin
    rst = 1; enable = 1; wr = 1; addr = 16'h0010; data_in = 16'hFFFF;
    rst1 = 1; en1 = 0; wr1 = 0; addr1 = 0; din1 = 0;

    // LATENCY=1: done one edge after accept, next accept the edge after that.
    step();
    chk("l1_rst_busy", busy1, 0);
    chk("l1_rst_dout", dout1, 16'h0000);
    rst1 = 0; en1 = 1; wr1 = 1; addr1 = 16'h0040; din1 = 16'h3C3C;
    step();
    chk("l1_e0_busy", busy1, 1);
    chk("l1_e0_done", done1, 0);
    wr1 = 0;
    step();
    chk("l1_e1_busy", busy1, 0);
    chk("l1_e1_done", done1, 1);
    chk("l1_e1_dout", dout1, 16'h0000);
    step();
    chk("l1_e2_busy", busy1, 1);
    chk("l1_e2_done", done1, 0);
    en1 = 0;
    step();
    chk("l1_e3_done", done1, 1);
    chk("l1_e3_dout", dout1, 16'h3C3C);
    step();
    chk("l1_e4_done", done1, 0);
    chk("l1_e4_busy", busy1, 0);

    // Reset held with enable high: nothing accepted.
    add(1, 1, 1, 16'h0010, 16'hFFFF, 0, 0, 16'h0000);
    add(1, 1, 1, 16'h0010, 16'hFFFF, 0, 0, 16'h0000);
    // Write BEEF then read it back.
    add(0, 1, 1, 16'h0010, 16'hBEEF, 1, 0, 16'h0000);
    addw(3, 1, 16'h0000);
    add(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h0000);
    add(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0000);
    addw(3, 1, 16'h0000);
    add(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'hBEEF);
    // Aliased reads.
    add(0, 1, 0, 16'h0011, 16'h0, 1, 0, 16'hBEEF);
    addw(3, 1, 16'hBEEF);
    add(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'hBEEF);
    add(0, 1, 0, 16'h0210, 16'h0, 1, 0, 16'hBEEF);
    addw(3, 1, 16'hBEEF);
    add(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'hBEEF);
    // Enable held through WAIT; next accept uses inputs at the done edge+1.
    add(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'hBEEF);
    add(0, 1, 1, 16'h0000, 16'h5555, 1, 0, 16'hBEEF);
    add(0, 1, 0, 16'h0002, 16'h0, 1, 0, 16'hBEEF);
    add(0, 1, 1, 16'h0004, 16'h6666, 1, 0, 16'hBEEF);
    add(0, 1, 1, 16'h0006, 16'h7777, 0, 1, 16'hBEEF);
    add(0, 1, 1, 16'h0020, 16'hA5A5, 1, 0, 16'hBEEF);
    addw(3, 1, 16'hBEEF);
    add(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'hBEEF);
    add(0, 1, 0, 16'h0020, 16'h0, 1, 0, 16'hBEEF);
    addw(3, 1, 16'hBEEF);
    add(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'hA5A5);
    // Reset two edges into a write: abandoned, storage untouched.
    add(0, 1, 1, 16'h0010, 16'h1234, 1, 0, 16'hA5A5);
    add(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'hA5A5);
    add(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0000);
    addw(4, 0, 16'h0000);
    add(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0000);
    addw(3, 1, 16'h0000);
    add(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'hBEEF);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; enable = tbl[i].en; wr = tbl[i].wr;
      addr = tbl[i].addr; data_in = tbl[i].din;
      step();
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_done", i), done, tbl[i].done);
      chk($sformatf("vec%0d_dout", i), data_out, tbl[i].dout);
    end

    // Fill every word through aliased byte addresses.
    for (int w = 0; w < 256; w++) begin
      rst = 0; enable = 1; wr = 1;
      addr = {7'($urandom), 8'(w), 1'($urandom)};
      data_in = 16'($urandom);
      for (int c = 0; c <= LAT; c++) begin
        step();
        enable = 0;
        chk($sformatf("fill%0d_busy", w), busy, m_busy);
        chk($sformatf("fill%0d_done", w), done, m_done);
        chk($sformatf("fill%0d_dout", w), data_out, m_dout);
      end
    end

    // Random traffic, including enable while busy and occasional reset.
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(0, 39) == 0);
      enable  = ($urandom_range(0, 9) < 7);
      wr      = 1'($urandom);
      addr    = 16'($urandom);
      data_in = 16'($urandom);
      step();
      chk($sformatf("rnd%0d_busy", c), busy, m_busy);
      chk($sformatf("rnd%0d_done", c), done, m_done);
      chk($sformatf("rnd%0d_dout", c), data_out, m_dout);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
